// File: rtl/alu_pkg.sv
// Shared constants and state type for the ALU arbiter.
// Six function codes and the arbiter FSM state enumeration.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'd16;
  localparam logic [5:0] OP_SUB = 6'd34;
  localparam logic [5:0] OP_AND = 6'd36;
  localparam logic [5:0] OP_OR  = 6'd35;
  localparam logic [5:0] OP_NOR = 6'd39;
  localparam logic [5:0] OP_SLT = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath shared by both requesters.
// Ports: a, b, op in; result, carry (ADD carry-out only) out.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      (op == OP_SUB): result = a - b;
      (op == OP_AND): result = a & b;
      (op == OP_OR):  result = a | b;
      (op == OP_NOR): result = ~(a | b);
      (op == OP_SLT): result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one shared ALU.
// Ports: clk/reset, two valid/ready requesters, one response port, opcount.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req0_op,
  input  logic [5:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_illegal,
  output logic [CNTW-1:0]  opcount
);

  state_t state, state_nx;

  logic             ptr;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [5:0]       op_q;
  logic             id_q;

  logic             gnt0;
  logic             gnt1;
  logic             take;
  logic             done;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic             legal;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res),
    .carry  (alu_cy)
  );

  assign legal = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                 (op_q == OP_AND) || (op_q == OP_OR)  ||
                 (op_q == OP_NOR) || (op_q == OP_SLT);

  always_comb begin
    state_nx = state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    unique case (state)
      S_IDLE: begin
        // lone requester wins; pointer breaks ties
        gnt0 = req0_valid && (!req1_valid || !ptr);
        gnt1 = req1_valid && (!req0_valid || ptr);
        if (gnt0 || gnt1) state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_RESP;
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign take       = gnt0 || gnt1;
  assign done       = (state == S_RESP) && rsp_ready;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      id_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        a_q  <= gnt1 ? req1_a  : req0_a;
        b_q  <= gnt1 ? req1_b  : req0_b;
        op_q <= gnt1 ? req1_op : req0_op;
        id_q <= gnt1;
        ptr  <= ~gnt1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
      opcount      <= '0;
    end else begin
      if (state == S_EXEC) begin
        rsp_id       <= id_q;
        rsp_result   <= legal ? alu_res : {{(WIDTH-1){1'b0}}, 1'b1};
        rsp_overflow <= legal && alu_cy;
        rsp_illegal  <= !legal;
      end
      if (done) opcount <= opcount + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_a, req1_a, req0_b, req1_b;
  logic [5:0]    req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]  rsp_result;
  logic          rsp_overflow, rsp_illegal;
  logic [CW-1:0] opcount;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .CNTW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req1_valid   (req1_valid),
    .req0_ready   (req0_ready),
    .req1_ready   (req1_ready),
    .req0_a       (req0_a),
    .req1_a       (req1_a),
    .req0_b       (req0_b),
    .req1_b       (req1_b),
    .req0_op      (req0_op),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal),
    .opcount      (opcount)
  );

  // reference: {illegal, overflow, result}
  function automatic logic [W+1:0] ref_alu(logic [5:0] op,
                                           logic [W-1:0] a,
                                           logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         ov, il;
    s  = {1'b0, a} + {1'b0, b};
    ov = 1'b0;
    il = 1'b0;
    case (op)
      6'd16: begin r = s[W-1:0]; ov = s[W]; end
      6'd34: r = a - b;
      6'd36: r = a & b;
      6'd35: r = a | b;
      6'd39: r = ~(a | b);
      6'd42: r = (a < b) ? 1 : 0;
      default: begin r = 1; il = 1'b1; end
    endcase
    return {il, ov, r};
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [5:0] op,
                        output logic [W-1:0] res, output logic ov,
                        output logic il, output logic rid);
    int n;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 10) begin
      checks++; failures++;
      $display("FAIL run_op_grant_timeout id=%0d", id);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 10) begin
      checks++; failures++;
      $display("FAIL run_op_rsp_timeout id=%0d", id);
    end
    res = rsp_result; ov = rsp_overflow; il = rsp_illegal; rid = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_overflow, rsp_illegal} !== 4'b0 ||
        rsp_result !== '0 || opcount !== '0 ||
        {req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got v=%b id=%b res=%h ov=%b il=%b cnt=%0d rdy=%b%b want zeros",
               rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_illegal,
               opcount, req0_ready, req1_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    req0_valid = 1'b1; req0_a = 5; req0_b = 7; req0_op = 6'd16;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL basic_grant got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      failures++;
      $display("FAIL basic_exec got v=%b rdy=%b%b want 000",
               rsp_valid, req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_id !== 1'b0 ||
        rsp_overflow !== 1'b0 || rsp_illegal !== 1'b0) begin
      failures++;
      $display("FAIL basic_rsp got v=%b res=%0d id=%b ov=%b il=%b want 1 12 0 0 0",
               rsp_valid, rsp_result, rsp_id, rsp_overflow, rsp_illegal);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (opcount !== 16'd1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_count got cnt=%0d v=%b want 1 0", opcount, rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic grants [4];
    logic last;
    int   ng;
    do_reset();
    req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_op = 6'd16;
    req1_valid = 1'b1; req1_a = 3; req1_b = 4; req1_op = 6'd16;
    rsp_ready  = 1'b1;
    ng   = 0;
    last = 1'b0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) begin
        checks++; failures++;
        $display("FAIL alt_double_grant at cycle %0d", c);
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== last) begin
          failures++;
          $display("FAIL alt_rsp_id got %b want %b", rsp_id, last);
        end
      end
      if (req0_ready || req1_ready) begin
        grants[ng] = req1_ready;
        last = req1_ready;
        ng++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (ng != 4 || grants[0] !== 1'b0 || grants[1] !== 1'b1 ||
        grants[2] !== 1'b0 || grants[3] !== 1'b1) begin
      failures++;
      $display("FAIL alt_order got n=%0d %b%b%b%b want 4 0101", ng,
               grants[0], grants[1], grants[2], grants[3]);
    end
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   op;
    logic [W-1:0] res;
    logic         ov;
    logic         il;
  } vec_t;

  task automatic test_ops();
    vec_t         v [6];
    logic [W-1:0] r;
    logic         ov, il, rid;
    v[0] = '{1'b0, 32'hFFFF_FFFF, 32'h1, 6'd16, 32'h0, 1'b1, 1'b0};
    v[1] = '{1'b1, 32'h0, 32'h1, 6'd34, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[2] = '{1'b0, 32'h1, 32'h8000_0000, 6'd42, 32'h1, 1'b0, 1'b0};
    v[3] = '{1'b1, 32'h1234, 32'h55, 6'd0, 32'h1, 1'b0, 1'b1};
    v[4] = '{1'b0, 32'h0, 32'h0, 6'd39, 32'hFFFF_FFFF, 1'b0, 1'b0};
    v[5] = '{1'b1, 32'h8000_0000, 32'h1, 6'd42, 32'h0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].id, v[i].a, v[i].b, v[i].op, r, ov, il, rid);
      checks++;
      if (r !== v[i].res || ov !== v[i].ov || il !== v[i].il ||
          rid !== v[i].id) begin
        failures++;
        $display("FAIL ops_%0d op=%0d got res=%h ov=%b il=%b id=%b want %h %b %b %b",
                 i, v[i].op, r, ov, il, rid, v[i].res, v[i].ov, v[i].il, v[i].id);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset();
    req1_valid = 1'b1; req1_a = 32'hF0F0; req1_b = 32'hFF00; req1_op = 6'd36;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 9; req0_b = 9; req0_op = 6'd16;
    n = 0;
    #1;
    while (!rsp_valid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 10) begin
      checks++; failures++;
      $display("FAIL stall_rsp_timeout");
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hF000 || rsp_id !== 1'b1 ||
          rsp_overflow !== 1'b0 || rsp_illegal !== 1'b0 ||
          {req0_ready, req1_ready} !== 2'b00 || opcount !== 16'd0) begin
        failures++;
        $display("FAIL stall_hold c=%0d got v=%b res=%h id=%b rdy=%b%b cnt=%0d want 1 f000 1 00 0",
                 c, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready, opcount);
      end
      @(negedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (opcount !== 16'd1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got cnt=%0d v=%b want 1 0", opcount, rsp_valid);
    end
  endtask

  task automatic test_reset_exec();
    do_reset();
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_op = 6'd16;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || opcount !== 16'd0) begin
        failures++;
        $display("FAIL rexec_discard c=%0d got v=%b cnt=%0d want 0 0",
                 c, rsp_valid, opcount);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rexec_pointer got %b%b want 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    logic [5:0]    legal_ops [6];
    logic          ptr;
    int            phase;
    logic [CW-1:0] cnt;
    logic          eid;
    logic [W+1:0]  exp;
    logic          g0, g1;
    legal_ops[0] = 6'd16; legal_ops[1] = 6'd34; legal_ops[2] = 6'd36;
    legal_ops[3] = 6'd35; legal_ops[4] = 6'd39; legal_ops[5] = 6'd42;
    do_reset();
    ptr   = 1'b0;
    phase = 0;
    cnt   = '0;
    eid   = 1'b0;
    exp   = '0;
    for (int c = 0; c < 400; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      if ($urandom_range(0, 3) == 0) req0_a = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) req1_b = 32'hFFFF_FFFF;
      req0_op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                            : legal_ops[$urandom_range(0, 5)];
      req1_op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                            : legal_ops[$urandom_range(0, 5)];
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (phase == 0) begin
        if (req0_valid && req1_valid) begin
          g0 = !ptr; g1 = ptr;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end
      checks++;
      if ({req0_ready, req1_ready} !== {g0, g1}) begin
        failures++;
        $display("FAIL rand_grant c=%0d got %b%b want %b%b",
                 c, req0_ready, req1_ready, g0, g1);
      end
      checks++;
      if (rsp_valid !== (phase == 2) || opcount !== cnt) begin
        failures++;
        $display("FAIL rand_status c=%0d got v=%b cnt=%0d want %b %0d",
                 c, rsp_valid, opcount, (phase == 2), cnt);
      end
      if (phase == 2) begin
        checks++;
        if ({rsp_illegal, rsp_overflow, rsp_result} !== exp || rsp_id !== eid) begin
          failures++;
          $display("FAIL rand_rsp c=%0d got il=%b ov=%b res=%h id=%b want %b %b %h %b",
                   c, rsp_illegal, rsp_overflow, rsp_result, rsp_id,
                   exp[W+1], exp[W], exp[W-1:0], eid);
        end
      end
      @(posedge clk);
      if (g0 || g1) begin
        eid   = g1;
        exp   = g1 ? ref_alu(req1_op, req1_a, req1_b)
                   : ref_alu(req0_op, req0_a, req0_b);
        ptr   = !g1;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && rsp_ready) begin
        phase = 0;
        cnt   = cnt + 1'b1;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_alternate();
    test_ops();
    test_stall();
    test_reset_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
